// File: rtl/riscv_core_trap_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
package riscv_core_trap_pkg;

  // Sequencer states: one CSR write per trap-path state, then a single redirect.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_MEPC    = 3'd1,
    WR_MCAUSE  = 3'd2,
    WR_MTVAL   = 3'd3,
    WR_MSTATUS = 3'd4,
    MRET_ST    = 3'd5,
    REDIRECT   = 3'd6
  } trap_state_e;

  // Machine-mode CSR addresses touched by the sequencer.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Exception cause codes.
  localparam logic [5:0] EXC_ILLEGAL    = 6'd2;
  localparam logic [5:0] EXC_BREAKPOINT = 6'd3;
  localparam logic [5:0] EXC_ECALL_M    = 6'd11;

  // Interrupt cause codes (mcause MSB set separately).
  localparam logic [5:0] IRQ_MSI = 6'd3;
  localparam logic [5:0] IRQ_MTI = 6'd7;
  localparam logic [5:0] IRQ_MEI = 6'd11;

  // Bit positions inside i_irq_pend = {MEI, MTI, MSI}.
  localparam int unsigned IRQ_PEND_MSI = 0;
  localparam int unsigned IRQ_PEND_MTI = 1;
  localparam int unsigned IRQ_PEND_MEI = 2;

  // mstatus field positions.
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Only mode 01 vectors; modes 00, 10 and 11 all behave as direct.
  function automatic logic mtvec_is_vectored(input logic [1:0] mode);
    return (mode == 2'b01);
  endfunction

endpackage

// File: rtl/riscv_core_trap_cause_encoder.sv
// Combinational priority encoder: picks interrupt, exception or MRET and
// produces the cause code and trap value for the sequencer to latch.
module riscv_core_trap_cause_encoder
  import riscv_core_trap_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            req_valid_i,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            illegal_i,
  input  logic [2:0]      irq_pend_i,
  input  logic            mie_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  output logic            take_trap_o,
  output logic            is_irq_o,
  output logic            is_mret_o,
  output logic [5:0]      cause_o,
  output logic [XLEN-1:0] tval_o
);

  // Interrupts beat exceptions, exceptions beat MRET.
  always_comb begin
    take_trap_o = 1'b0;
    is_irq_o    = 1'b0;
    is_mret_o   = 1'b0;
    cause_o     = '0;
    tval_o      = '0;
    if (mie_i && (irq_pend_i != 3'b000)) begin
      take_trap_o = 1'b1;
      is_irq_o    = 1'b1;
      if (irq_pend_i[IRQ_PEND_MEI])      cause_o = IRQ_MEI;
      else if (irq_pend_i[IRQ_PEND_MSI]) cause_o = IRQ_MSI;
      else                               cause_o = IRQ_MTI;
    end else if (req_valid_i && (illegal_i || ebreak_i || ecall_i)) begin
      take_trap_o = 1'b1;
      if (illegal_i) begin
        cause_o = EXC_ILLEGAL;
        tval_o  = {{(XLEN-ILEN){1'b0}}, instr_i};
      end else if (ebreak_i) begin
        cause_o = EXC_BREAKPOINT;
        tval_o  = pc_i;
      end else begin
        cause_o = EXC_ECALL_M;
      end
    end else if (req_valid_i && mret_i && !illegal_i) begin
      is_mret_o = 1'b1;
    end
  end

endmodule

// File: rtl/riscv_core_trap_sequencer.sv
// Machine-mode trap/return sequencer: serialises mepc/mcause/mtval/mstatus
// writes through the single CSR write port, then issues one redirect+flush.
module riscv_core_trap_sequencer
  import riscv_core_trap_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_mret,
  input  logic            i_illegal,
  input  logic [XLEN-1:0] i_pc,
  input  logic [ILEN-1:0] i_instr,
  input  logic [2:0]      i_irq_pend,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_req_ack,
  output logic            o_busy,
  output logic            o_csr_wr_en,
  output logic [11:0]     o_csr_wr_addr,
  output logic [XLEN-1:0] o_csr_wr_data,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush
);

  trap_state_e     state_q, state_d;
  logic            is_irq_q;
  logic            is_mret_q;
  logic [5:0]      cause_q;
  logic [XLEN-1:0] pc_q, tval_q, mstatus_q, mtvec_q, mepc_q;

  logic            enc_take_trap, enc_is_irq, enc_is_mret;
  logic [5:0]      enc_cause;
  logic [XLEN-1:0] enc_tval;
  logic            accept;

  riscv_core_trap_cause_encoder #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_cause_encoder (
    .req_valid_i (i_req_valid),
    .ecall_i     (i_ecall),
    .ebreak_i    (i_ebreak),
    .mret_i      (i_mret),
    .illegal_i   (i_illegal),
    .irq_pend_i  (i_irq_pend),
    .mie_i       (i_mstatus[MSTATUS_MIE]),
    .pc_i        (i_pc),
    .instr_i     (i_instr),
    .take_trap_o (enc_take_trap),
    .is_irq_o    (enc_is_irq),
    .is_mret_o   (enc_is_mret),
    .cause_o     (enc_cause),
    .tval_o      (enc_tval)
  );

  // Reset blocks acceptance so nothing is acknowledged in the reset cycle.
  assign accept = !i_rst && (state_q == IDLE) && (enc_take_trap || enc_is_mret);

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (accept) state_d = enc_take_trap ? WR_MEPC : MRET_ST;
      WR_MEPC:    state_d = WR_MCAUSE;
      WR_MCAUSE:  state_d = WR_MTVAL;
      WR_MTVAL:   state_d = WR_MSTATUS;
      WR_MSTATUS: state_d = REDIRECT;
      MRET_ST:    state_d = REDIRECT;
      REDIRECT:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State register and context latched at accept time.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_irq_q  <= enc_is_irq;
        is_mret_q <= enc_is_mret;
        cause_q   <= enc_cause;
        pc_q      <= {i_pc[XLEN-1:2], 2'b00};
        tval_q    <= enc_tval;
        mstatus_q <= i_mstatus;
        mtvec_q   <= i_mtvec;
        mepc_q    <= i_mepc;
      end
    end
  end

  // CSR write mux and redirect outputs, all forced low during reset.
  always_comb begin
    logic [XLEN-1:0] ms;
    logic [XLEN-1:0] base;
    ms               = mstatus_q;
    base             = {mtvec_q[XLEN-1:2], 2'b00};
    o_req_ack        = accept;
    o_busy           = !i_rst && (state_q != IDLE);
    o_csr_wr_en      = 1'b0;
    o_csr_wr_addr    = '0;
    o_csr_wr_data    = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_flush          = 1'b0;
    if (!i_rst) begin
      case (state_q)
        WR_MEPC: begin
          o_csr_wr_en   = 1'b1;
          o_csr_wr_addr = CSR_MEPC;
          o_csr_wr_data = pc_q;
        end
        WR_MCAUSE: begin
          o_csr_wr_en   = 1'b1;
          o_csr_wr_addr = CSR_MCAUSE;
          o_csr_wr_data = {is_irq_q, {(XLEN-7){1'b0}}, cause_q};
        end
        WR_MTVAL: begin
          o_csr_wr_en   = 1'b1;
          o_csr_wr_addr = CSR_MTVAL;
          o_csr_wr_data = tval_q;
        end
        WR_MSTATUS: begin
          ms[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
          ms[MSTATUS_MIE]                   = 1'b0;
          ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
          o_csr_wr_en   = 1'b1;
          o_csr_wr_addr = CSR_MSTATUS;
          o_csr_wr_data = ms;
        end
        MRET_ST: begin
          ms[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
          ms[MSTATUS_MPIE]                  = 1'b1;
          ms[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
          o_csr_wr_en   = 1'b1;
          o_csr_wr_addr = CSR_MSTATUS;
          o_csr_wr_data = ms;
        end
        REDIRECT: begin
          o_redirect_valid = 1'b1;
          o_flush          = 1'b1;
          if (is_mret_q)
            o_redirect_pc = mepc_q;
          else if (mtvec_is_vectored(mtvec_q[1:0]) && is_irq_q)
            o_redirect_pc = base + {{(XLEN-8){1'b0}}, cause_q, 2'b00};
          else
            o_redirect_pc = base;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_trap_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// cycle by cycle against a transaction-level reference model.
module tb_riscv_core_trap_sequencer;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, ecall, ebreak, mret, illegal;
  logic [XLEN-1:0] pc, mstatus, mtvec, mepc;
  logic [ILEN-1:0] instr;
  logic [2:0]      irq_pend;
  logic            req_ack, busy, csr_wr_en, redirect_valid, flush;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data, redirect_pc;

  always #5 clk = ~clk;

  riscv_core_trap_sequencer #(.XLEN(XLEN), .ILEN(ILEN)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .i_ecall          (ecall),
    .i_ebreak         (ebreak),
    .i_mret           (mret),
    .i_illegal        (illegal),
    .i_pc             (pc),
    .i_instr          (instr),
    .i_irq_pend       (irq_pend),
    .i_mstatus        (mstatus),
    .i_mtvec          (mtvec),
    .i_mepc           (mepc),
    .o_req_ack        (req_ack),
    .o_busy           (busy),
    .o_csr_wr_en      (csr_wr_en),
    .o_csr_wr_addr    (csr_wr_addr),
    .o_csr_wr_data    (csr_wr_data),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_flush          (flush)
  );

  // One expected busy cycle: either a CSR write or the redirect.
  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [63:0] data;
    logic        rd;
    logic [63:0] rpc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t wr_rec(input logic [11:0] a, input logic [63:0] d);
    exp_t r;
    r = '0; r.wr = 1'b1; r.addr = a; r.data = d;
    return r;
  endfunction

  function automatic exp_t rd_rec(input logic [63:0] target);
    exp_t r;
    r = '0; r.rd = 1'b1; r.rpc = target;
    return r;
  endfunction

  // Reference model: decides whether this idle cycle accepts and, if so,
  // queues the whole expected transaction.
  function automatic logic model_accept();
    logic        irq_take, exc_take;
    logic [63:0] cause, tval, ms, base, target;
    irq_take = mstatus[3] && (irq_pend != 3'b000);
    exc_take = req_valid && (illegal || ebreak || ecall);
    if (irq_take || exc_take) begin
      tval = 64'd0;
      if (irq_take) begin
        if (irq_pend[2])      cause = 64'd11;
        else if (irq_pend[0]) cause = 64'd3;
        else                  cause = 64'd7;
      end else if (illegal) begin
        cause = 64'd2; tval = 64'(instr);
      end else if (ebreak) begin
        cause = 64'd3; tval = pc;
      end else begin
        cause = 64'd11;
      end
      ms = mstatus;
      ms[7] = mstatus[3];
      ms[3] = 1'b0;
      ms[12:11] = 2'b11;
      base = mtvec & ~64'd3;
      target = (mtvec[1:0] == 2'b01 && irq_take) ? base + 64'd4 * cause : base;
      q.push_back(wr_rec(12'h341, pc & ~64'd3));
      q.push_back(wr_rec(12'h342, irq_take ? (cause | (64'd1 << 63)) : cause));
      q.push_back(wr_rec(12'h343, tval));
      q.push_back(wr_rec(12'h300, ms));
      q.push_back(rd_rec(target));
      return 1'b1;
    end
    if (req_valid && mret && !illegal) begin
      ms = mstatus;
      ms[3] = mstatus[7];
      ms[7] = 1'b1;
      ms[12:11] = 2'b11;
      q.push_back(wr_rec(12'h300, ms));
      q.push_back(rd_rec(mepc));
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Evaluate one cycle: inputs were set just after the previous negedge.
  task automatic step();
    exp_t e;
    logic e_ack, e_busy;
    #1;
    e = '0; e_ack = 1'b0; e_busy = 1'b0;
    if (!rst) begin
      if (q.size() != 0) begin
        e = q[0];
        e_busy = 1'b1;
      end else begin
        e_ack = model_accept();
      end
    end
    check_eq("ack",      64'(req_ack),        64'(e_ack));
    check_eq("busy",     64'(busy),           64'(e_busy));
    check_eq("wr_en",    64'(csr_wr_en),      64'(e.wr));
    check_eq("wr_addr",  64'(csr_wr_addr),    64'(e.addr));
    check_eq("wr_data",  csr_wr_data,         e.data);
    check_eq("redirect", 64'(redirect_valid), 64'(e.rd));
    check_eq("rd_pc",    redirect_pc,         e.rpc);
    check_eq("flush",    64'(flush),          64'(e.rd));
    if (rst) q.delete();
    else if (e_busy) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic quiet();
    req_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; illegal = 1'b0;
    irq_pend = 3'b000;
  endtask

  // Idle the inputs until the model is back in IDLE (bounded).
  task automatic drain();
    quiet();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    if (q.size() != 0) check_eq("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic apply(input logic rv, input logic ec, input logic eb, input logic mr,
                       input logic il, input logic [2:0] irq, input logic [63:0] p,
                       input logic [31:0] ins, input logic [63:0] ms,
                       input logic [63:0] tv, input logic [63:0] ep);
    req_valid = rv; ecall = ec; ebreak = eb; mret = mr; illegal = il;
    irq_pend = irq; pc = p; instr = ins; mstatus = ms; mtvec = tv; mepc = ep;
    step();
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    pc = '0; instr = '0; mstatus = '0; mtvec = '0; mepc = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    // ECALL, direct mtvec, MIE=1
    apply(1, 1, 0, 0, 0, 3'b000, 64'h8000_0100, 32'h0000_0073, 64'h8, 64'h8000_0000, 64'h0);
    drain();
    // Illegal with all-ones instruction, then illegal+ecall together
    apply(1, 0, 0, 0, 1, 3'b000, 64'h8000_0200, 32'hFFFF_FFFF, 64'h0, 64'h8000_0000, 64'h0);
    drain();
    apply(1, 1, 0, 0, 1, 3'b000, 64'h8000_0204, 32'h1234_5678, 64'h88, 64'h8000_0003, 64'h0);
    drain();
    // EBREAK: mtval = pc
    apply(1, 0, 1, 0, 0, 3'b000, 64'h8000_0302, 32'h0010_0073, 64'h0, 64'h8000_0002, 64'h0);
    drain();
    // Vectored interrupt beating a concurrent ECALL
    apply(1, 1, 0, 0, 0, 3'b110, 64'h8000_0400, 32'h0, 64'h8, 64'h8000_0001, 64'h0);
    drain();
    // MRET with MPIE=1
    apply(1, 0, 0, 1, 0, 3'b000, 64'h8000_0500, 32'h3020_0073, 64'h80, 64'h0, 64'h8000_0204);
    drain();
    // MRET together with illegal: taken as illegal exception
    apply(1, 0, 0, 1, 1, 3'b000, 64'h8000_0600, 32'h3020_0073, 64'h80, 64'h8000_0000, 64'h0);
    drain();
    // Flagless request ignored
    apply(1, 0, 0, 0, 0, 3'b000, 64'h8000_0700, 32'h0, 64'h8, 64'h8000_0000, 64'h0);
    // Masked interrupt: no ack; then enabled: MSI taken
    apply(0, 0, 0, 0, 0, 3'b001, 64'h8000_0800, 32'h0, 64'h0, 64'h8000_0001, 64'h0);
    apply(0, 0, 0, 0, 0, 3'b001, 64'h8000_0800, 32'h0, 64'h8, 64'h8000_0001, 64'h0);
    drain();
    // Reset in WR_MCAUSE; request held throughout busy
    apply(1, 1, 0, 0, 0, 3'b000, 64'h8000_0900, 32'h0, 64'h8, 64'h8000_0000, 64'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    quiet();
    step();
    step();
    // Held ECALL during busy, accepted again right after REDIRECT
    apply(1, 1, 0, 0, 0, 3'b000, 64'h8000_0A00, 32'h0, 64'h8, 64'h8000_0000, 64'h0);
    for (int i = 0; i < 7; i++) step();
    drain();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      ecall     = $urandom_range(0, 3) == 0;
      ebreak    = $urandom_range(0, 3) == 0;
      mret      = $urandom_range(0, 3) == 0;
      illegal   = $urandom_range(0, 3) == 0;
      irq_pend  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      pc        = {$urandom, $urandom};
      instr     = $urandom;
      mstatus   = {$urandom, $urandom};
      mtvec     = {$urandom, $urandom};
      mepc      = {$urandom, $urandom};
      step();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
